// File: rtl/demux_1to4.sv
// 1-to-4 demultiplexer with enable and registered outputs.
// D is steered to one of Y0..Y3 by {S1,S0}; every other output, and all outputs
// while disabled or in reset, are driven to zero. Latency is one clock.
module demux_1to4 #(
  parameter int unsigned DATA_W = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] D,
  input  logic              S0,
  input  logic              S1,
  input  logic              EN,
  output logic [DATA_W-1:0] Y0,
  output logic [DATA_W-1:0] Y1,
  output logic [DATA_W-1:0] Y2,
  output logic [DATA_W-1:0] Y3
);

  logic [1:0]        sel;
  logic [DATA_W-1:0] y0_d, y1_d, y2_d, y3_d;
  logic [DATA_W-1:0] y0_q, y1_q, y2_q, y3_q;

  assign sel = {S1, S0};

  // Next-state routing: exactly one output may carry D, the rest are zero.
  always_comb begin
    y0_d = '0;
    y1_d = '0;
    y2_d = '0;
    y3_d = '0;
    if (EN) begin
      unique case (sel)
        2'b00:   y0_d = D;
        2'b01:   y1_d = D;
        2'b10:   y2_d = D;
        2'b11:   y3_d = D;
        default: ;
      endcase
    end
  end

  // Output registers; synchronous reset dominates enable and select.
  always_ff @(posedge clk) begin
    if (rst) begin
      y0_q <= '0;
      y1_q <= '0;
      y2_q <= '0;
      y3_q <= '0;
    end else begin
      y0_q <= y0_d;
      y1_q <= y1_d;
      y2_q <= y2_d;
      y3_q <= y3_d;
    end
  end

  assign Y0 = y0_q;
  assign Y1 = y1_q;
  assign Y2 = y2_q;
  assign Y3 = y3_q;

endmodule

// File: tb/tb_demux_1to4.sv
// Directed bench for demux_1to4: a 1-bit instance for routing/enable/reset
// behaviour and an 8-bit instance for wide data.
module tb_demux_1to4;

  logic       clk;
  logic       rst;
  logic       s0, s1, en;
  logic       d1;
  logic [7:0] d8;
  logic       y0_1, y1_1, y2_1, y3_1;
  logic [7:0] y0_8, y1_8, y2_8, y3_8;

  int checks;
  int failures;

  demux_1to4 #(.DATA_W(1)) u_dut1 (
    .clk (clk),
    .rst (rst),
    .D   (d1),
    .S0  (s0),
    .S1  (s1),
    .EN  (en),
    .Y0  (y0_1),
    .Y1  (y1_1),
    .Y2  (y2_1),
    .Y3  (y3_1)
  );

  demux_1to4 #(.DATA_W(8)) u_dut8 (
    .clk (clk),
    .rst (rst),
    .D   (d8),
    .S0  (s0),
    .S1  (s1),
    .EN  (en),
    .Y0  (y0_8),
    .Y1  (y1_8),
    .Y2  (y2_8),
    .Y3  (y3_8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one rising edge and settle before sampling.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic set_sel(input logic [1:0] s);
    {s1, s0} = s;
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst = 1'b1; en = 1'b1; d1 = 1'b1; d8 = 8'hA5;
    set_sel(2'b11);

    // Reset held two cycles with EN=1, D=1, sel=11.
    step();
    check("rst_c1_y3210", {28'd0, y3_1, y2_1, y1_1, y0_1}, 32'h0);
    check("rst_c1_wide", {y3_8, y2_8, y1_8, y0_8}, 32'h0);
    step();
    check("rst_c2_y3210", {28'd0, y3_1, y2_1, y1_1, y0_1}, 32'h0);

    // Release reset: next edge routes to Y3.
    rst = 1'b0;
    step();
    check("rst_release", {28'd0, y3_1, y2_1, y1_1, y0_1}, 32'b1000);
    check("rst_release_wide", {y3_8, y2_8, y1_8, y0_8}, 32'hA500_0000);

    // Sweep all four selects.
    set_sel(2'b00); step();
    check("sweep_00", {28'd0, y3_1, y2_1, y1_1, y0_1}, 32'b0001);
    set_sel(2'b01); step();
    check("sweep_01", {28'd0, y3_1, y2_1, y1_1, y0_1}, 32'b0010);
    set_sel(2'b10); step();
    check("sweep_10", {28'd0, y3_1, y2_1, y1_1, y0_1}, 32'b0100);
    set_sel(2'b11); step();
    check("sweep_11", {28'd0, y3_1, y2_1, y1_1, y0_1}, 32'b1000);

    // Disable clears everything, re-enable routes again.
    en = 1'b0; set_sel(2'b10); step();
    check("disable", {28'd0, y3_1, y2_1, y1_1, y0_1}, 32'b0000);
    check("disable_wide", {y3_8, y2_8, y1_8, y0_8}, 32'h0);
    en = 1'b1; set_sel(2'b00); step();
    check("reenable_00", {28'd0, y3_1, y2_1, y1_1, y0_1}, 32'b0001);

    // Zero data: all outputs stay zero for every select.
    d1 = 1'b0;
    for (int i = 0; i < 4; i++) begin
      set_sel(i[1:0]); step();
      check($sformatf("zero_data_sel%0d", i), {28'd0, y3_1, y2_1, y1_1, y0_1}, 32'b0000);
    end

    // Back-to-back select switch 01 -> 10, no overlap.
    d1 = 1'b1;
    set_sel(2'b01); step();
    check("switch_01", {28'd0, y3_1, y2_1, y1_1, y0_1}, 32'b0010);
    set_sel(2'b10); step();
    check("switch_10", {28'd0, y3_1, y2_1, y1_1, y0_1}, 32'b0100);

    // Outputs hold between edges.
    #3;
    check("hold_mid_cycle", {28'd0, y3_1, y2_1, y1_1, y0_1}, 32'b0100);

    // Wide data routed to Y2.
    d8 = 8'hA5; set_sel(2'b10); step();
    check("wide_y2", {24'd0, y2_8}, 32'hA5);
    check("wide_others", {8'd0, y3_8, y1_8, y0_8}, 32'h0);
    d8 = 8'h3C; set_sel(2'b01); step();
    check("wide_y1_3c", {y3_8, y2_8, y1_8, y0_8}, 32'h0000_3C00);

    // Reset mid-stream clears on the next edge and holds while asserted.
    set_sel(2'b10); d8 = 8'hA5; rst = 1'b1; step();
    check("mid_rst_wide", {y3_8, y2_8, y1_8, y0_8}, 32'h0);
    check("mid_rst_narrow", {28'd0, y3_1, y2_1, y1_1, y0_1}, 32'b0000);
    en = 1'b0; step();
    check("mid_rst_hold", {y3_8, y2_8, y1_8, y0_8}, 32'h0);
    en = 1'b1; rst = 1'b0; step();
    check("post_rst_resume", {y3_8, y2_8, y1_8, y0_8}, 32'h00A5_0000);
    check("post_rst_resume_narrow", {28'd0, y3_1, y2_1, y1_1, y0_1}, 32'b0100);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
